fifo_sync_flags: RTL and testbench
==================================

// Module: fifo_sync_flags
// PURPOSE
//  Parametrised synchronous single-clock FIFO; successor to the basic writeEn/readEn FIFO.
//  Adds occupancy count, programmable almost-full/almost-empty thresholds and sticky
//  overflow/underflow error flags. Illegal push/pop is tolerated: dropped and flagged, not assumed away.
//  Sits between producer/consumer datapaths in the same clock domain.
// PARAMETERS
//  DataWidth       32          data word width in bits
//  Depth           8           number of entries; power of 2, >= 2
//  PtrWidth        $clog2(Depth)  address width; pointers are PtrWidth+1 bits (wrap bit)
//  AlmostFullThr   Depth-2     almostFull when count >= this; legal 1..Depth
//  AlmostEmptyThr  2           almostEmpty when count <= this; legal 0..Depth-1
// PORTS
//  clk          in   1           clock; all logic on posedge
//  rst          in   1           synchronous reset, active-high
//  writeEn      in   1           push request
//  writeData    in   DataWidth   push data
//  readEn       in   1           pop request
//  clrErr       in   1           one-cycle pulse; clears overflow/underflow
//  readData     out  DataWidth   pop data (timing per CONFIGURATION)
//  full         out  1           count == Depth
//  empty        out  1           count == 0
//  almostFull   out  1           count >= AlmostFullThr
//  almostEmpty  out  1           count <= AlmostEmptyThr
//  count        out  PtrWidth+1  occupancy, 0..Depth
//  overflow     out  1           sticky: push attempted while full
//  underflow    out  1           sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wrPtr=rdPtr=0, count=0, empty=1, full=0, almostEmpty=1,
//    almostFull=0, overflow=0, underflow=0, readData=0. mem not reset. rst beats all inputs.
//  - Push accepted iff writeEn && !full (full sampled this cycle): mem[wrPtr[PtrWidth-1:0]]<=writeData,
//    wrPtr<=wrPtr+1. Pop accepted iff readEn && !empty: rdPtr<=rdPtr+1.
//  - Pointers wrap modulo 2*Depth; address = low PtrWidth bits, wraps Depth-1 -> 0.
//  - count = wrPtr - rdPtr (PtrWidth+1-bit modulo subtract); all flags decode from
//    registered pointers, so they change the cycle after the accepted op.
//  - Simultaneous push+pop, 0<count<Depth: both accepted, count unchanged.
//  - Push+pop when full: pop accepted, push dropped, overflow<=1, count -> Depth-1.
//  - Push+pop when empty: push accepted, pop rejected, underflow<=1, count -> 1.
//  - Rejected op: no pointer, mem or readData change.
//  - overflow/underflow hold until rst or clrErr; a new error in the clrErr cycle wins (flag stays 1).
//  - Never full && empty simultaneously; count never exceeds Depth.
// CONFIGURATION
//  FIFO_FWFT_EN undefined (standard mode): readData registered; cycle after an accepted pop
//    readData = word at old rdPtr; holds value otherwise; latency 1 cycle.
//  FIFO_FWFT_EN defined (first-word-fall-through): readData = mem[rdPtr[PtrWidth-1:0]],
//    combinational from registered state; head valid whenever !empty; readEn acts as ack,
//    next word visible the cycle after. readData undefined-but-stable while empty.
//  All other behaviour identical in both modes.
// TESTING (Depth=8, DataWidth=32, AlmostFullThr=6, AlmostEmptyThr=2)
//  1 rst, push 0x11..0x88 on 8 consecutive cycles -> almostFull=1 after 6th, full=1,count=8 after 8th, almostEmpty=0 after 3rd.
//  2 from full, pop 8 cycles -> readData 0x11..0x88 in order (std: 1 cycle after each readEn; FWFT: head before ack); empty=1, count=0.
//  3 full, push 0xDEAD -> dropped, overflow=1, count=8; later pop returns 0x11..; clrErr -> overflow=0 next cycle.
//  4 empty, readEn=1 -> underflow=1, rdPtr/readData unchanged; same cycle clrErr+readEn -> underflow stays 1.
//  5 count=3, push+pop every cycle x12 -> count stays 3, both pointers wrap past 7, data order preserved.
//  6 count=5, rst with writeEn=readEn=1 -> next cycle count=0, empty=1, almostEmpty=1, errors 0; next pushes start at addr 0.

Source files
------------

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bundle for fifo_sync_flags: push/pop requests, data and status flags.
interface fifo_sync_flags_if #(
  parameter int DataWidth = 32,
  parameter int PtrWidth  = 3
);
  logic                 writeEn;
  logic [DataWidth-1:0] writeData;
  logic                 readEn;
  logic                 clrErr;
  logic [DataWidth-1:0] readData;
  logic                 full;
  logic                 empty;
  logic                 almostFull;
  logic                 almostEmpty;
  logic [PtrWidth:0]    count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output writeEn, writeData, readEn, clrErr,
    input  readData, full, empty, almostFull, almostEmpty, count, overflow, underflow
  );

  modport slave (
    input  writeEn, writeData, readEn, clrErr,
    output readData, full, empty, almostFull, almostEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through readData; default is registered 1-cycle read.
module fifo_sync_flags #(
  parameter int DataWidth      = 32,
  parameter int Depth          = 8,
  parameter int PtrWidth       = $clog2(Depth),
  parameter int AlmostFullThr  = Depth - 2,
  parameter int AlmostEmptyThr = 2
) (
  input logic            clk,
  input logic            rst,
  fifo_sync_flags_if.slave bus
);
  localparam logic [PtrWidth:0] DepthCnt = (PtrWidth + 1)'(Depth);
  localparam logic [PtrWidth:0] AfThr    = (PtrWidth + 1)'(AlmostFullThr);
  localparam logic [PtrWidth:0] AeThr    = (PtrWidth + 1)'(AlmostEmptyThr);
  localparam logic [PtrWidth:0] PtrOne   = (PtrWidth + 1)'(1);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrWidth:0]    wr_ptr;
  logic [PtrWidth:0]    rd_ptr;
  logic [PtrWidth:0]    occupancy;
  logic [PtrWidth-1:0]  rd_addr;
  logic                 is_full;
  logic                 is_empty;
  logic                 push_ok;
  logic                 pop_ok;
  logic                 overflow_q;
  logic                 underflow_q;

  // The extra wrap bit lets a plain subtract distinguish full from empty.
  assign occupancy = wr_ptr - rd_ptr;
  assign rd_addr   = rd_ptr[PtrWidth-1:0];
  assign is_full   = (occupancy == DepthCnt);
  assign is_empty  = (occupancy == '0);
  assign push_ok   = bus.writeEn && !is_full;
  assign pop_ok    = bus.readEn && !is_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrOne;
      if (pop_ok)  rd_ptr <= rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr[PtrWidth-1:0]] <= bus.writeData;
  end

  // A fresh error in the same cycle as clrErr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.writeEn && is_full) overflow_q <= 1'b1;
      else if (bus.clrErr)        overflow_q <= 1'b0;
      if (bus.readEn && is_empty) underflow_q <= 1'b1;
      else if (bus.clrErr)        underflow_q <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.readData = mem[rd_addr];
`else
  logic [DataWidth-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst)         rd_data_q <= '0;
    else if (pop_ok) rd_data_q <= mem[rd_addr];
  end

  assign bus.readData = rd_data_q;
`endif

  assign bus.count       = occupancy;
  assign bus.full        = is_full;
  assign bus.empty       = is_empty;
  assign bus.almostFull  = (occupancy >= AfThr);
  assign bus.almostEmpty = (occupancy <= AeThr);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags (Depth=8, thresholds 6/2) with a queue-based reference.
module tb_fifo_sync_flags;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_sync_flags_if #(.DataWidth(32), .PtrWidth(3)) bus ();

  fifo_sync_flags #(
    .DataWidth(32), .Depth(8), .AlmostFullThr(6), .AlmostEmptyThr(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  int          mcnt;
  bit          m_ovf, m_unf, last_pop;
  logic [31:0] obs_rd, last_exp;
  logic [9:0]  obs_flags;

  assign obs_flags = {bus.count, bus.full, bus.empty, bus.almostFull, bus.almostEmpty,
                      bus.overflow, bus.underflow};

  function automatic logic [9:0] exp_flags();
    return {4'(mcnt), mcnt == 8, mcnt == 0, mcnt >= 6, mcnt <= 2, m_ovf, m_unf};
  endfunction

  // One clock of stimulus; the reference decides acceptance and queues the expected pop word.
  task automatic drive(input bit we, input logic [31:0] wd, input bit re, input bit clr);
    bit push_ok, pop_ok;
    bus.writeEn   = we;
    bus.writeData = wd;
    bus.readEn    = re;
    bus.clrErr    = clr;
    push_ok = we && (mcnt < 8);
    pop_ok  = re && (mcnt > 0);
    if (pop_ok)  exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(wd);
    if (we && mcnt == 8) m_ovf = 1'b1;
    else if (clr)        m_ovf = 1'b0;
    if (re && mcnt == 0) m_unf = 1'b1;
    else if (clr)        m_unf = 1'b0;
    mcnt = model_q.size();
`ifdef FIFO_FWFT_EN
    obs_rd = bus.readData;
`endif
    @(posedge clk);
    #1;
`ifndef FIFO_FWFT_EN
    obs_rd = bus.readData;
`endif
    last_pop      = pop_ok;
    bus.writeEn   = 1'b0;
    bus.readEn    = 1'b0;
    bus.clrErr    = 1'b0;
  endtask

  task automatic do_reset(input bit we, input bit re);
    bus.writeEn   = we;
    bus.readEn    = re;
    bus.writeData = 32'hBAD0_BAD0;
    bus.clrErr    = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.writeEn = 1'b0;
    bus.readEn  = 1'b0;
    model_q.delete();
    exp_q.delete();
    mcnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    last_pop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    if (obs_flags !== 10'b0000_0_1_0_1_0_0) begin
      $display("FAIL reset_flags: got %b want %b", obs_flags, 10'b0000_0_1_0_1_0_0);
      n_fail++;
    end
    n_checks++;
`ifndef FIFO_FWFT_EN
    if (bus.readData !== 32'h0) begin
      $display("FAIL reset_rdata: got %h want 0", bus.readData);
      n_fail++;
    end
    n_checks++;
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 1'b0, 1'b0);
      if (obs_flags !== exp_flags()) begin
        $display("FAIL fill_flags[%0d]: got %b want %b", i, obs_flags, exp_flags());
        n_fail++;
      end
      n_checks++;
    end
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      $display("FAIL fill_full: got count=%0d full=%b empty=%b want 8 1 0",
               bus.count, bus.full, bus.empty);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      if (last_pop) begin
        last_exp = exp_q.pop_front();
        if (obs_rd !== last_exp) begin
          $display("FAIL drain_data[%0d]: got %h want %h", i, obs_rd, last_exp);
          n_fail++;
        end
        n_checks++;
      end
      if (obs_flags !== exp_flags()) begin
        $display("FAIL drain_flags[%0d]: got %b want %b", i, obs_flags, exp_flags());
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h11 * (i + 1), 1'b0, 1'b0);
    drive(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    if (obs_flags !== exp_flags() || bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
      $display("FAIL ovf_set: got %b want %b", obs_flags, exp_flags());
      n_fail++;
    end
    n_checks++;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    last_exp = exp_q.pop_front();
    if (obs_rd !== last_exp || obs_rd !== 32'h11) begin
      $display("FAIL ovf_pop: got %h want %h", obs_rd, last_exp);
      n_fail++;
    end
    n_checks++;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    if (obs_flags !== exp_flags() || bus.overflow !== 1'b0) begin
      $display("FAIL ovf_clr: got %b want %b", obs_flags, exp_flags());
      n_fail++;
    end
    n_checks++;
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    // push+pop while full: pop wins, push dropped and flagged
    drive(1'b1, 32'hEEEE, 1'b1, 1'b0);
    last_exp = exp_q.pop_front();
    if (obs_rd !== last_exp || obs_flags !== exp_flags()) begin
      $display("FAIL ovf_pushpop: got rd=%h flags=%b want rd=%h flags=%b",
               obs_rd, obs_flags, last_exp, exp_flags());
      n_fail++;
    end
    n_checks++;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_underflow();
    test_drain(mcnt);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    if (obs_flags !== exp_flags() || bus.underflow !== 1'b1) begin
      $display("FAIL unf_set: got %b want %b", obs_flags, exp_flags());
      n_fail++;
    end
    n_checks++;
`ifndef FIFO_FWFT_EN
    if (bus.readData !== last_exp) begin
      $display("FAIL unf_rdata_hold: got %h want %h", bus.readData, last_exp);
      n_fail++;
    end
    n_checks++;
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    if (bus.underflow !== 1'b1 || obs_flags !== exp_flags()) begin
      $display("FAIL unf_clr_race: got %b want %b", obs_flags, exp_flags());
      n_fail++;
    end
    n_checks++;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hAB, 1'b1, 1'b0);
    if (obs_flags !== exp_flags() || bus.count !== 4'd1) begin
      $display("FAIL unf_pushpop: got %b want %b", obs_flags, exp_flags());
      n_fail++;
    end
    n_checks++;
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    last_exp = exp_q.pop_front();
    if (obs_rd !== last_exp || obs_flags !== exp_flags()) begin
      $display("FAIL unf_drain: got rd=%h flags=%b want rd=%h flags=%b",
               obs_rd, obs_flags, last_exp, exp_flags());
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h100 + i, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h200 + i, 1'b1, 1'b0);
      last_exp = exp_q.pop_front();
      if (obs_rd !== last_exp || obs_flags !== exp_flags() || bus.count !== 4'd3) begin
        $display("FAIL b2b[%0d]: got rd=%h flags=%b want rd=%h flags=%b",
                 i, obs_rd, obs_flags, last_exp, exp_flags());
        n_fail++;
      end
      n_checks++;
    end
    test_drain(3);
  endtask

  task automatic test_reset_midway();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h300 + i, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFF, 1'b1, 1'b0);
    do_reset(1'b1, 1'b1);
    if (obs_flags !== 10'b0000_0_1_0_1_0_0) begin
      $display("FAIL rst_mid_flags: got %b want %b", obs_flags, 10'b0000_0_1_0_1_0_0);
      n_fail++;
    end
    n_checks++;
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 1'b0, 1'b0);
    test_drain(2);
  endtask

  initial begin
    bus.writeEn   = 1'b0;
    bus.writeData = 32'h0;
    bus.readEn    = 1'b0;
    bus.clrErr    = 1'b0;
    test_reset();
    test_fill();
    test_drain(8);
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
